// File: rtl/shift_reg_413.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : shift_reg_413                                                  |
// | Purpose  : Variable-depth (1..MAX_DEPTH) delay line, circular-buffer      |
// |            history with registered tap output.                            |
// | Options  : SHIFTREG_CE_EN adds a clock-enable input `ce`.                 |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module shift_reg_413 #(
  parameter int DATA_WIDTH = 64,
  parameter int MAX_DEPTH  = 413,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef SHIFTREG_CE_EN
  input  logic                  ce,
`endif
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int                PTR_W      = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
  localparam logic [PTR_W:0]    C_DEPTH    = (PTR_W+1)'(MAX_DEPTH);
  localparam logic [PTR_W-1:0]  C_LAST     = PTR_W'(MAX_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] C_MAX_ADDR = ADDR_WIDTH'(MAX_DEPTH);

  logic                  en;
  logic [DATA_WIDTH-1:0] mem_q [MAX_DEPTH];
  logic [PTR_W-1:0]      wr_q;
  logic [PTR_W-1:0]      wr_d;
  logic [DATA_WIDTH-1:0] dout_q;
  logic [DATA_WIDTH-1:0] dout_d;
  logic [ADDR_WIDTH-1:0] dly_m1;
  logic [PTR_W:0]        rd_sum;
  logic [PTR_W-1:0]      rd_idx;

`ifdef SHIFTREG_CE_EN
  assign en = ce;
`else
  assign en = 1'b1;
`endif

  // dly_m1 is the effective delay minus one: how many edges back the tap
  // reaches into stored history (0 means forward din straight to dout).
  always_comb begin
    dly_m1 = '0;
    if (addr == '0) begin
      dly_m1 = '0;
    end else if (addr > C_MAX_ADDR) begin
      dly_m1 = C_MAX_ADDR - ADDR_WIDTH'(1);
    end else begin
      dly_m1 = addr - ADDR_WIDTH'(1);
    end
  end

  always_comb begin
    rd_sum = {1'b0, wr_q} + C_DEPTH - (PTR_W+1)'(dly_m1);
    rd_idx = (rd_sum >= C_DEPTH) ? PTR_W'(rd_sum - C_DEPTH) : PTR_W'(rd_sum);
    wr_d   = (wr_q == C_LAST) ? '0 : wr_q + PTR_W'(1);
    dout_d = (dly_m1 == '0) ? din : mem_q[rd_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q   <= '0;
      dout_q <= '0;
    end else if (en) begin
      mem_q[wr_q] <= din;
      wr_q        <= wr_d;
      dout_q      <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_reg_413.sv
`default_nettype none
// Testbench for shift_reg_413: directed phases with random data, checked
// against a history-queue reference model of the delay line.
module tb_shift_reg_413;

  localparam int DW = 64;
  localparam int MD = 413;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          ce;
  logic [DW-1:0] din;
  logic [AW-1:0] addr;
  logic [DW-1:0] dout;

  always #5 clk = ~clk;

  shift_reg_413 #(
    .DATA_WIDTH(DW),
    .MAX_DEPTH (MD),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk (clk),
    .rst (rst),
`ifdef SHIFTREG_CE_EN
    .ce  (ce),
`endif
    .din (din),
    .addr(addr),
    .dout(dout)
  );

  logic [DW-1:0] hist[$];
  logic [DW-1:0] exp_q;
  int            n_tests = 0;
  int            n_fail  = 0;

  function automatic int eff_delay(input logic [AW-1:0] a);
    if (a == 0)       return 1;
    else if (a > MD)  return MD;
    else              return int'(a);
  endfunction

  function automatic logic [DW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] expv);
    n_tests++;
    assert (dout === expv) else begin
      n_fail++;
      $error("FAIL %s: dout=%h expected=%h", tag, dout, expv);
    end
  endtask

  // Called at a falling edge; applies inputs, models the rising edge, checks.
  task automatic step(input string tag, input logic [DW-1:0] d, input logic [AW-1:0] a);
    int n;
    int dl;
    din  = d;
    addr = a;
    @(posedge clk);
    if (rst) begin
      hist.delete();
      exp_q = '0;
    end else if (ce) begin
      hist.push_back(d);
      n  = hist.size();
      dl = eff_delay(a);
      exp_q = (n >= dl) ? hist[n-dl] : '0;
    end
    #1 check(tag, exp_q);
    @(negedge clk);
  endtask

  initial begin
    logic [DW-1:0] ramp;
    logic [AW-1:0] ra;
    rst   = 1'b0;
    ce    = 1'b1;
    din   = '1;
    addr  = 7;
    exp_q = '0;

    // Power-up reset with all-ones data on the input
    @(negedge clk);
    rst = 1'b1;
    #1 check("rst_assert", '0);
    @(negedge clk);
    step("rst_hold", '1, 7);
    step("rst_hold", '1, 7);
    rst = 1'b0;

    // Fixed depth 7, then switch to 3 mid-stream, then hold the last word
    for (int i = 0; i < 25; i++) begin
      step(i < 10 ? "depth7" : "depth3", DW'(i), (i < 10) ? AW'(7) : AW'(3));
    end
    for (int i = 0; i < 5; i++) step("stream_end", DW'(24), 3);

    // Boundary depths
    for (int i = 0; i < 20; i++) step("addr0", rnd64(), 0);
    for (int i = 0; i < 20; i++) step("addr1", rnd64(), 1);
    ramp = 64'h1000;
    for (int i = 0; i < 450; i++) begin
      step("addr413", ramp, AW'(MD));
      ramp++;
    end
    for (int i = 0; i < 450; i++) begin
      step("addr500", ramp, AW'(500));
      ramp++;
    end

    // Random depth changes over retained history
    ra = AW'($urandom_range(0, 511));
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) ra = AW'($urandom_range(0, 511));
`ifdef SHIFTREG_CE_EN
      ce = ($urandom_range(0, 3) != 0);
`endif
      step("rand", rnd64(), ra);
    end
    ce = 1'b1;

    // Asynchronous reset pulse between edges
    #2 rst = 1'b1;
    #1 check("async_rst", '0);
    hist.delete();
    exp_q = '0;
    #1 rst = 1'b0;
    for (int i = 0; i < 30; i++) step("post_rst", rnd64(), 7);

`ifdef SHIFTREG_CE_EN
    for (int i = 0; i < 24; i++) begin
      ce = (i % 3 != 1);
      step("ce_gate", DW'(i + 100), 4);
    end
    ce = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
